// File: rtl/ad9252_tx_emu.sv
// AD9252 serial LVDS transmit emulator: per-lane 14-bit SDR serialiser, FCO stream and data-to-FCO skew.
// Define AD9252_TX_PN_EN to build the PN9 generator for test_mode 7; otherwise mode 7 sends midscale.

module ad9252_tx_emu #(
    parameter int ADC_CHANEL = 4
) (
    input  logic                      ad_dco_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic [2:0]                test_mode_i,
    input  logic [3:0]                bit_offset_i,
    input  logic [ADC_CHANEL*14-1:0]  data_in_i,
    input  logic                      data_valid_i,
    output logic                      data_ready_o,
    output logic [ADC_CHANEL-1:0]     ser_data_o,
    output logic                      ser_fco_o,
    output logic                      frame_start_o,
    output logic                      underrun_o,
    output logic [15:0]               frame_cnt_o
);

    localparam logic [2:0]  MODE_USER     = 3'd0;
    localparam logic [2:0]  MODE_MIDSCALE = 3'd1;
    localparam logic [2:0]  MODE_POS_FS   = 3'd2;
    localparam logic [2:0]  MODE_NEG_FS   = 3'd3;
    localparam logic [2:0]  MODE_CHECKER  = 3'd4;
    localparam logic [2:0]  MODE_TOGGLE   = 3'd5;
    localparam logic [2:0]  MODE_RAMP     = 3'd6;
    localparam logic [3:0]  LAST_BIT      = 4'd13;
    localparam logic [13:0] MIDSCALE      = 14'h2000;

    logic [3:0]                   bit_cnt_q, bit_cnt_d;
    logic [ADC_CHANEL-1:0][13:0]  shreg_q, shreg_d;
    logic [ADC_CHANEL-1:0][13:0]  dly_q, dly_d;
    logic                         fco_q, fco_d;
    logic                         fstart_q, fstart_d;
    logic                         udr_pend_q, udr_pend_d;
    logic                         underrun_q, underrun_d;
    logic [15:0]                  frame_cnt_q, frame_cnt_d;
    logic                         checker_q, checker_d;
    logic                         toggle_q, toggle_d;
    logic [13:0]                  ramp_q, ramp_d;
    logic [13:0]                  pat_word;
    logic [ADC_CHANEL-1:0]        ser_bit;
    logic [3:0]                   tap;
    logic                         load;

    assign load         = enable_i && (bit_cnt_q == LAST_BIT);
    assign data_ready_o = !reset_i && load && (test_mode_i == MODE_USER);
    assign tap          = (bit_offset_i > LAST_BIT) ? LAST_BIT : bit_offset_i;

    assign ser_fco_o     = fco_q;
    assign frame_start_o = fstart_q;
    assign underrun_o    = underrun_q;
    assign frame_cnt_o   = frame_cnt_q;

    always_comb begin
        for (int i = 0; i < ADC_CHANEL; i++) begin
            ser_data_o[i] = dly_q[i][tap];
        end
    end

    always_comb begin
        case (test_mode_i)
            MODE_MIDSCALE: pat_word = MIDSCALE;
            MODE_POS_FS:   pat_word = 14'h3FFF;
            MODE_NEG_FS:   pat_word = 14'h0000;
            MODE_CHECKER:  pat_word = checker_q ? 14'h1555 : 14'h2AAA;
            MODE_TOGGLE:   pat_word = toggle_q ? 14'h0000 : 14'h3FFF;
            MODE_RAMP:     pat_word = ramp_q;
            default:       pat_word = MIDSCALE;
        endcase
    end

`ifdef AD9252_TX_PN_EN
    localparam logic [2:0] MODE_PN = 3'd7;
    logic [8:0] lfsr_q, lfsr_d;

    assign lfsr_d = (enable_i && (test_mode_i == MODE_PN)) ? {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]} : lfsr_q;

    always_ff @(posedge ad_dco_i) begin
        if (reset_i) lfsr_q <= 9'h1FF;
        else         lfsr_q <= lfsr_d;
    end
`endif

    // PN9 bypasses the frame shifters so its stream stays continuous across loads
    always_comb begin
        for (int i = 0; i < ADC_CHANEL; i++) begin
            ser_bit[i] = shreg_q[i][13];
        end
`ifdef AD9252_TX_PN_EN
        if (test_mode_i == MODE_PN) ser_bit = {ADC_CHANEL{lfsr_q[8]}};
`endif
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        frame_cnt_d = frame_cnt_q;
        checker_d   = checker_q;
        toggle_d    = toggle_q;
        ramp_d      = ramp_q;
        if (!enable_i) begin
            bit_cnt_d = LAST_BIT;
            shreg_d   = '0;
        end else if (load) begin
            bit_cnt_d   = 4'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            for (int i = 0; i < ADC_CHANEL; i++) begin
                if (test_mode_i == MODE_USER) shreg_d[i] = data_valid_i ? data_in_i[14*i +: 14] : MIDSCALE;
                else                          shreg_d[i] = pat_word;
            end
            case (test_mode_i)
                MODE_CHECKER: checker_d = ~checker_q;
                MODE_TOGGLE:  toggle_d  = ~toggle_q;
                MODE_RAMP:    ramp_d    = ramp_q + 14'd1;
                default:      ;
            endcase
        end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            for (int i = 0; i < ADC_CHANEL; i++) begin
                shreg_d[i] = {shreg_q[i][12:0], 1'b0};
            end
        end
        // Outputs are registered one stage after the shifter, so flags align with the first serial bit
        udr_pend_d = load && (test_mode_i == MODE_USER) && !data_valid_i;
        underrun_d = enable_i && udr_pend_q;
        fco_d      = enable_i && (bit_cnt_q <= 4'd6);
        fstart_d   = enable_i && (bit_cnt_q == 4'd0);
        for (int i = 0; i < ADC_CHANEL; i++) begin
            dly_d[i] = {dly_q[i][12:0], enable_i & ser_bit[i]};
        end
    end

    always_ff @(posedge ad_dco_i) begin
        if (reset_i) begin
            bit_cnt_q   <= LAST_BIT;
            shreg_q     <= '0;
            dly_q       <= '0;
            fco_q       <= 1'b0;
            fstart_q    <= 1'b0;
            udr_pend_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= '0;
            checker_q   <= 1'b0;
            toggle_q    <= 1'b0;
            ramp_q      <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            dly_q       <= dly_d;
            fco_q       <= fco_d;
            fstart_q    <= fstart_d;
            udr_pend_q  <= udr_pend_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
            checker_q   <= checker_d;
            toggle_q    <= toggle_d;
            ramp_q      <= ramp_d;
        end
    end

endmodule

// File: tb/tb_ad9252_tx_emu.sv
// Self-checking bench for ad9252_tx_emu: vector table, directed corner sequences, randomized run vs. frame-level model.
module tb_ad9252_tx_emu;

    localparam int NL = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            valid = 1'b0;
    logic [2:0]      mode = 3'd0;
    logic [3:0]      off = 4'd0;
    logic [NL*14-1:0] din = '0;
    logic            ready;
    logic [NL-1:0]   sdata;
    logic            fco, fs, udr;
    logic [15:0]     fcnt;

    always #5 clk = ~clk;

    ad9252_tx_emu #(.ADC_CHANEL(NL)) dut (
        .ad_dco_i     (clk),
        .reset_i      (rst),
        .enable_i     (en),
        .test_mode_i  (mode),
        .bit_offset_i (off),
        .data_in_i    (din),
        .data_valid_i (valid),
        .data_ready_o (ready),
        .ser_data_o   (sdata),
        .ser_fco_o    (fco),
        .frame_start_o(fs),
        .underrun_o   (udr),
        .frame_cnt_o  (fcnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level reference: each load schedules 14 output beats; disabling discards the schedule
    typedef struct {
        logic [NL-1:0] bits;
        logic          fco;
        logic          fs;
        logic          udr;
    } beat_t;

    beat_t         sched[$];
    logic [NL-1:0] hist[$];
    beat_t         cur;
    int unsigned   m_fc, n_chk, n_tog, n_ramp, pn_idx;
    bit            pn_seq[520];
    logic          ready_seen;

    task automatic model_reset();
        sched.delete();
        hist.delete();
        for (int k = 0; k < 15; k++) hist.push_back('0);
        m_fc = 0; n_chk = 0; n_tog = 0; n_ramp = 0; pn_idx = 0;
        cur.bits = '0; cur.fco = 0; cur.fs = 0; cur.udr = 0;
    endtask

    task automatic model_edge();
        beat_t       e;
        beat_t       nb;
        logic [13:0] w[NL];
        bit          ld, uflag;
        int          sz;
        e.bits = '0; e.fco = 0; e.fs = 0; e.udr = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (en) begin
            sz = sched.size();
            ld = (sz <= 1);
            if (sz > 0) e = sched.pop_front();
`ifdef AD9252_TX_PN_EN
            if (mode == 3'd7) begin
                e.bits = {NL{pn_seq[pn_idx % 511]}};
                pn_idx++;
            end
`endif
            if (ld) begin
                uflag = 0;
                for (int i = 0; i < NL; i++) begin
                    case (mode)
                        3'd0: begin
                            if (valid) w[i] = din[14*i +: 14];
                            else begin w[i] = 14'h2000; uflag = 1; end
                        end
                        3'd1: w[i] = 14'h2000;
                        3'd2: w[i] = 14'h3FFF;
                        3'd3: w[i] = 14'h0000;
                        3'd4: w[i] = (n_chk % 2 == 1) ? 14'h1555 : 14'h2AAA;
                        3'd5: w[i] = (n_tog % 2 == 1) ? 14'h0000 : 14'h3FFF;
                        3'd6: w[i] = 14'(n_ramp % 16384);
                        default: w[i] = 14'h2000;
                    endcase
                end
                if (mode == 3'd4) n_chk++;
                if (mode == 3'd5) n_tog++;
                if (mode == 3'd6) n_ramp++;
                m_fc = (m_fc + 1) % 65536;
                for (int k = 0; k < 14; k++) begin
                    for (int i = 0; i < NL; i++) nb.bits[i] = w[i][13-k];
                    nb.fco = (k < 7);
                    nb.fs  = (k == 0);
                    nb.udr = uflag && (k == 0);
                    sched.push_back(nb);
                end
            end
        end else begin
            sched.delete();
        end
        hist.push_back(e.bits);
        if (hist.size() > 20) void'(hist.pop_front());
        cur = e;
    endtask

    task automatic step();
        logic exp_rdy;
        int   tp;
        @(negedge clk);
        exp_rdy = !rst && en && (mode == 3'd0) && (sched.size() <= 1);
        ready_seen = ready;
        chk("data_ready", 32'(ready), 32'(exp_rdy));
        @(posedge clk);
        model_edge();
        #1;
        tp = (off > 4'd13) ? 13 : int'(off);
        chk("ser_data",    32'(sdata), 32'(hist[hist.size()-1-tp]));
        chk("ser_fco",     32'(fco),   32'(cur.fco));
        chk("frame_start", 32'(fs),    32'(cur.fs));
        chk("underrun",    32'(udr),   32'(cur.udr));
        chk("frame_cnt",   32'(fcnt),  32'(m_fc));
    endtask

    task automatic capture(output logic [13:0] w, output int un);
        w = '0; un = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            w = {w[12:0], sdata[0]};
            un += int'(udr);
        end
    endtask

    typedef struct {
        bit          rst, en;
        bit          exp_ready, exp_sd0, exp_fco, exp_fs;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t        tbl[20];
    logic [13:0] w0 = 14'h3A5C;
    logic [13:0] cw;
    logic [13:0] exp4[4];
    int          un;
    bit          found;

    initial begin
        for (int k = 0; k < 9; k++) pn_seq[k] = 1'b1;
        for (int k = 0; k < 511; k++) pn_seq[k+9] = pn_seq[k] ^ pn_seq[k+4];
        model_reset();

        for (int r = 0; r < 20; r++) begin
            tbl[r].rst = (r < 3);
            tbl[r].en  = (r >= 4);
            tbl[r].exp_ready = (r == 4) || (r == 18);
            tbl[r].exp_sd0 = 0; tbl[r].exp_fco = 0; tbl[r].exp_fs = 0;
            tbl[r].exp_fc = (r < 4) ? 16'd0 : ((r >= 18) ? 16'd2 : 16'd1);
            if (r >= 5 && r <= 18) begin
                tbl[r].exp_sd0 = w0[13-(r-5)];
                tbl[r].exp_fco = ((r - 5) < 7);
                tbl[r].exp_fs  = (r == 5);
            end
            if (r == 19) begin
                tbl[r].exp_sd0 = w0[13]; tbl[r].exp_fco = 1; tbl[r].exp_fs = 1;
            end
        end

        // Vector table: reset with data_valid high, idle, then one full 0x3A5C frame and the next load
        mode = 3'd0; off = 4'd0; valid = 1'b1;
        din = {14'h3FFF, 14'h2000, 14'h0001, w0};
        for (int r = 0; r < 20; r++) begin
            rst = tbl[r].rst; en = tbl[r].en;
            step();
            chk("tbl_ready", 32'(ready_seen), 32'(tbl[r].exp_ready));
            chk("tbl_sd0",   32'(sdata[0]),   32'(tbl[r].exp_sd0));
            chk("tbl_fco",   32'(fco),        32'(tbl[r].exp_fco));
            chk("tbl_fs",    32'(fs),         32'(tbl[r].exp_fs));
            chk("tbl_fcnt",  32'(fcnt),       32'(tbl[r].exp_fc));
        end

        // Underrun: one load with data_valid low
        valid = 1'b0; found = 0;
        for (int k = 0; k < 14 && !found; k++) begin
            step();
            if (ready_seen) found = 1;
        end
        chk("underrun_load_seen", 32'(found), 32'd1);
        valid = 1'b1;
        capture(cw, un);
        chk("underrun_word", 32'(cw), 32'h2000);
        chk("underrun_pulses", 32'(un), 32'd1);

        // Skew sweep
        off = 4'd3;  for (int k = 0; k < 40; k++) step();
        off = 4'd13; for (int k = 0; k < 40; k++) step();
        off = 4'd15; for (int k = 0; k < 30; k++) step();
        off = 4'd0;

        // Checkerboard from reset
        exp4[0] = 14'h2AAA; exp4[1] = 14'h1555; exp4[2] = 14'h2AAA; exp4[3] = 14'h1555;
        rst = 1; en = 0; step(); step();
        rst = 0; mode = 3'd4; en = 1; step();
        for (int f = 0; f < 4; f++) begin
            capture(cw, un);
            chk("checker_word", 32'(cw), 32'(exp4[f]));
        end

        // Ramp and toggle from reset
        rst = 1; en = 0; step();
        rst = 0; mode = 3'd6; en = 1; step();
        for (int f = 0; f < 3; f++) begin
            capture(cw, un);
            chk("ramp_word", 32'(cw), 32'(f));
        end
        mode = 3'd5;
        for (int f = 0; f < 3; f++) begin
            capture(cw, un);
            if (f > 0) chk("toggle_word", 32'(cw), (f == 1) ? 32'h3FFF : 32'h0000);
        end

        // Abort at bit_cnt 5 then restart
        rst = 1; en = 0; step();
        rst = 0; mode = 3'd0; valid = 1; en = 1;
        din = {$urandom, $urandom};
        step();
        for (int k = 0; k < 5; k++) step();
        en = 0; step();
        chk("abort_fco",   32'(fco),   32'd0);
        chk("abort_fs",    32'(fs),    32'd0);
        chk("abort_sdata", 32'(sdata), 32'd0);
        en = 1; step();
        chk("restart_ready", 32'(ready_seen), 32'd1);
        capture(cw, un);
        chk("restart_word", 32'(cw), 32'(din[13:0]));

`ifdef AD9252_TX_PN_EN
        rst = 1; en = 0; step();
        rst = 0; mode = 3'd7; en = 1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("pn_bit", 32'(sdata[0]), (k <= 9) ? 32'd1 : 32'd0);
        end
`endif

        // Randomized run against the model
        rst = 0; en = 1;
        for (int k = 0; k < 4000; k++) begin
            rst   = ($urandom_range(399) == 0);
            en    = ($urandom_range(49) != 0);
            valid = ($urandom_range(4) != 0);
            if ($urandom_range(29) == 0) mode = 3'($urandom_range(7));
            if ($urandom_range(39) == 0) off  = 4'($urandom_range(15));
            din = {$urandom, $urandom};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
